// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
// Shared types for the data-memory path: the data-cache address layout, the
// store width encoding, the port data width, and the store write buffer
// entry format.
//
// Address layout (32 bits, MSB first):
//   tag[19:0] | index[7:0] | chip_sel[1:0] | byte_sel[1:0]
// A "word" is identified by tag, index and chip_sel. byte_sel only selects
// a byte within that word.
// -----------------------------------------------------------------------------
package data_memory_pkg;

  localparam int PORT_WIDTH         = 32;
  localparam int WRITE_BUFFER_DEPTH = 4;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_op_width_t;

  typedef struct packed {
    logic [19:0] tag;
    logic [7:0]  index;
    logic [1:0]  chip_sel;
    logic [1:0]  byte_sel;
  } data_cache_addr_t;

  typedef struct packed {
    data_cache_addr_t        address;
    logic [PORT_WIDTH-1:0]   data;
    mem_op_width_t           width;
  } write_buffer_entry_t;

  // True when both addresses refer to the same word; byte_sel is ignored.
  function automatic logic same_word(input data_cache_addr_t a,
                                     input data_cache_addr_t b);
    return (a.tag == b.tag) && (a.index == b.index) &&
           (a.chip_sel == b.chip_sel);
  endfunction

endpackage

// File: rtl/store_write_buffer.sv
// -----------------------------------------------------------------------------
// store_write_buffer
// Circular FIFO of pending stores sitting between the store path of the data
// cache and memory. The head entry is presented to memory one request at a
// time; each request waits for a one-cycle acknowledge. In-flight loads are
// checked against every buffered store so the load path can stall or forward.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset; discards all entries
//   write_buffer_i  push strobe, one cycle per store
//   address_i       store address
//   data_i          store data
//   data_width_i    store width
//   full_o          no free entry
//   empty_o         no valid entry
//   load_address_i  address of an in-flight load
//   load_match_o    a buffered store hits the same word as the load
//   mem_write_o     memory write request (head entry valid on mem_*_o)
//   mem_address_o   head entry address, 0 when not requesting
//   mem_data_o      head entry data, 0 when not requesting
//   mem_width_o     head entry width, 0 when not requesting
//   mem_done_i      memory write acknowledge, one cycle
// -----------------------------------------------------------------------------
module store_write_buffer
  import data_memory_pkg::*;
#(
  parameter int DEPTH = WRITE_BUFFER_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_buffer_i,
  input  data_cache_addr_t      address_i,
  input  logic [PORT_WIDTH-1:0] data_i,
  input  mem_op_width_t         data_width_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  data_cache_addr_t      load_address_i,
  output logic                  load_match_o,
  output logic                  mem_write_o,
  output data_cache_addr_t      mem_address_o,
  output logic [PORT_WIDTH-1:0] mem_data_o,
  output mem_op_width_t         mem_width_o,
  input  logic                  mem_done_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    S_IDLE,
    S_REQUEST
  } state_t;

  write_buffer_entry_t entries_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;

  logic push_accept;
  logic pop;
  write_buffer_entry_t in_entry;
  write_buffer_entry_t out_entry;

  // Status flags come from the count register only, so they never depend
  // combinationally on this cycle's inputs.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // A push while full is dropped even when the head retires this cycle.
  assign push_accept = write_buffer_i & ~full_o;
  assign pop         = (state_q == S_REQUEST) & mem_done_i;

  assign in_entry = '{address: address_i, data: data_i, width: data_width_i};

  // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_accept) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push_accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: control state (pointers, count, FSM) is reset because correctness
  // depends on it; the entry array is not, since an entry is only ever read
  // after it has been written and counted valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_accept) begin
      entries_q[tail_q] <= in_entry;
    end
  end

  // Request FSM. IDLE always lasts at least one cycle, which gives the
  // memory side a bubble between consecutive writes.
  always_comb begin
    state_d     = state_q;
    mem_write_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty_o) begin
          state_d = S_REQUEST;
        end
      end
      S_REQUEST: begin
        mem_write_o = 1'b1;
        if (mem_done_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Head entry cannot move during REQUEST (head only advances on the ack),
  // so the presented fields stay stable until acknowledged.
  assign out_entry     = mem_write_o ? entries_q[head_q] : '0;
  assign mem_address_o = out_entry.address;
  assign mem_data_o    = out_entry.data;
  assign mem_width_o   = out_entry.width;

  // Entry i is valid when its distance from head is below count. The entry
  // being pushed this cycle is not counted yet; the entry being acknowledged
  // still is, so a load never slips past a store that is still in flight.
  always_comb begin
    logic [PTR_W-1:0] offset;
    load_match_o = 1'b0;
    offset       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      if (({1'b0, offset} < count_q) &&
          same_word(entries_q[i].address, load_address_i)) begin
        load_match_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_write_buffer
// Directed scenarios for the store write buffer followed by a randomized run
// checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_store_write_buffer;
  import data_memory_pkg::*;

  localparam int DEPTH = 4;

  logic                  clk;
  logic                  rst;
  logic                  wr;
  data_cache_addr_t      addr;
  logic [PORT_WIDTH-1:0] data;
  mem_op_width_t         width;
  logic                  full_o;
  logic                  empty_o;
  data_cache_addr_t      load_addr;
  logic                  load_match_o;
  logic                  mem_write_o;
  data_cache_addr_t      mem_address_o;
  logic [PORT_WIDTH-1:0] mem_data_o;
  mem_op_width_t         mem_width_o;
  logic                  done;

  int errors = 0;
  int checks = 0;

  // Reference model: the buffered stores in FIFO order, plus whether a
  // memory request is currently being presented.
  write_buffer_entry_t mq[$];
  bit                  mreq;

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .write_buffer_i (wr),
    .address_i      (addr),
    .data_i         (data),
    .data_width_i   (width),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .load_address_i (load_addr),
    .load_match_o   (load_match_o),
    .mem_write_o    (mem_write_o),
    .mem_address_o  (mem_address_o),
    .mem_data_o     (mem_data_o),
    .mem_width_o    (mem_width_o),
    .mem_done_i     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; the model follows the behavioural rules, then outputs
  // are given 1 ns to settle before anyone samples them.
  task automatic tick();
    bit pop, push, nreq;
    write_buffer_entry_t e;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mreq = 1'b0;
    end else begin
      e    = '{address: addr, data: data, width: width};
      pop  = mreq && done;
      push = wr && (mq.size() < DEPTH);
      nreq = mreq ? !done : (mq.size() != 0);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      mreq = nreq;
    end
    #1;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                            input mem_op_width_t w);
    wr = 1'b1; addr = a; data = d; width = w;
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!mem_write_o && n < 8) begin
      tick();
      n++;
    end
    ok = mem_write_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; done = 1'b0; addr = '0; data = '0;
    width = MEM_BYTE; load_addr = '0;
    #2;
    checks++;
    if ({empty_o, full_o, mem_write_o, load_match_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: empty/full/req/match=%b expected 1000",
               {empty_o, full_o, mem_write_o, load_match_o});
    end
    checks++;
    if ({mem_address_o, mem_data_o, mem_width_o} !== '0) begin
      errors++;
      $display("FAIL reset_mem_fields: addr=%h data=%h width=%0d expected 0",
               mem_address_o, mem_data_o, mem_width_o);
    end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    push_store(32'h0000_1004, 32'hDEAD_BEEF, MEM_WORD);
    checks++;
    if (mem_write_o !== 1'b0 || empty_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_gap: req=%b empty=%b expected req=0 empty=0",
               mem_write_o, empty_o);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem_write_o !== 1'b1 || mem_address_o !== 32'h0000_1004 ||
          mem_data_o !== 32'hDEAD_BEEF || mem_width_o !== MEM_WORD) begin
        errors++;
        $display("FAIL single_request[%0d]: req=%b addr=%h data=%h width=%0d expected 1/00001004/deadbeef/2",
                 k, mem_write_o, mem_address_o, mem_data_o, mem_width_o);
      end
      if (k < 2) tick();
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (empty_o !== 1'b1 || mem_write_o !== 1'b0 || mem_data_o !== '0) begin
      errors++;
      $display("FAIL single_drained: empty=%b req=%b data=%h expected 1/0/0",
               empty_o, mem_write_o, mem_data_o);
    end
    ok = 1'b1;
  endtask

  task automatic test_full();
    bit ok;
    for (int i = 0; i < 4; i++)
      push_store(32'h0000_3000 + 32'(i * 4), 32'h100 + 32'(i), MEM_WORD);
    checks++;
    if (full_o !== 1'b1) begin
      errors++;
      $display("FAIL full_after_4: full=%b expected 1", full_o);
    end
    push_store(32'h0000_3010, 32'h0000_0BAD, MEM_WORD);
    checks++;
    if (full_o !== 1'b1) begin
      errors++;
      $display("FAIL full_after_5th: full=%b expected 1", full_o);
    end
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      checks++;
      if (!ok || mem_data_o !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL full_drain[%0d]: req=%b data=%h expected req=1 data=%h",
                 i, mem_write_o, mem_data_o, 32'h100 + 32'(i));
      end
      done = 1'b1; tick(); done = 1'b0;
    end
    repeat (3) tick();
    checks++;
    if (empty_o !== 1'b1 || mem_write_o !== 1'b0) begin
      errors++;
      $display("FAIL full_5th_dropped: empty=%b req=%b data=%h expected empty=1 req=0",
               empty_o, mem_write_o, mem_data_o);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 3; i++)
      push_store(32'h0000_4000 + 32'(i * 16), 32'hA0 + 32'(i), MEM_HALF);
    wait_req(ok);
    checks++;
    if (!ok || mem_data_o !== 32'hA0) begin
      errors++;
      $display("FAIL b2b_first: req=%b data=%h expected 1/000000a0", mem_write_o, mem_data_o);
    end
    // Push and acknowledge on the same edge.
    wr = 1'b1; addr = 32'h0000_4030; data = 32'hA3; width = MEM_HALF; done = 1'b1;
    tick();
    wr = 1'b0; done = 1'b0;
    checks++;
    if (mem_write_o !== 1'b0 || full_o !== 1'b0 || empty_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: req=%b full=%b empty=%b expected 0/0/0",
               mem_write_o, full_o, empty_o);
    end
    tick();
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (mem_write_o !== 1'b1 || mem_data_o !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: req=%b data=%h expected 1/%h",
                 i, mem_write_o, mem_data_o, 32'hA0 + 32'(i));
      end
      done = 1'b1; tick(); done = 1'b0;
      if (i < 3) tick();
    end
    checks++;
    if (empty_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_empty: empty=%b expected 1", empty_o);
    end
  endtask

  task automatic test_load_match();
    bit ok;
    load_addr = 32'h0000_2003;
    wr = 1'b1; addr = 32'h0000_2000; data = 32'h55; width = MEM_WORD;
    #1;
    checks++;
    if (load_match_o !== 1'b0) begin
      errors++;
      $display("FAIL match_pushing_excluded: match=%b expected 0", load_match_o);
    end
    tick();
    wr = 1'b0;
    #1;
    checks++;
    if (load_match_o !== 1'b1) begin
      errors++;
      $display("FAIL match_same_word: match=%b expected 1", load_match_o);
    end
    load_addr = 32'h0000_2004;
    #1;
    checks++;
    if (load_match_o !== 1'b0) begin
      errors++;
      $display("FAIL match_other_word: match=%b expected 0", load_match_o);
    end
    wait_req(ok);
    load_addr = 32'h0000_2003; done = 1'b1;
    #1;
    checks++;
    if (!ok || load_match_o !== 1'b1) begin
      errors++;
      $display("FAIL match_during_ack: req=%b match=%b expected 1/1", mem_write_o, load_match_o);
    end
    tick();
    done = 1'b0;
    #1;
    checks++;
    if (load_match_o !== 1'b0) begin
      errors++;
      $display("FAIL match_after_ack: match=%b expected 0", load_match_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    push_store(32'h0000_5000, 32'h11, MEM_WORD);
    push_store(32'h0000_5010, 32'h22, MEM_WORD);
    wait_req(ok);
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || mem_write_o !== 1'b0 || empty_o !== 1'b1 || mem_data_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_request: ok=%b req=%b empty=%b data=%h expected 1/0/1/0",
               ok, mem_write_o, empty_o, mem_data_o);
    end
    mq.delete(); mreq = 1'b0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (mem_write_o !== 1'b0 || empty_o !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_no_requests: activity seen after reset release, expected none");
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] d;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      push_store(32'h0000_6000 + 32'(i * 4), d, MEM_WORD);
      wait_req(ok);
      checks++;
      if (!ok || mem_data_o !== d || full_o !== 1'b0) begin
        errors++;
        $display("FAIL wrap[%0d]: req=%b data=%h full=%b expected 1/%h/0",
                 i, mem_write_o, mem_data_o, full_o, d);
      end
      done = 1'b1; tick(); done = 1'b0;
      checks++;
      if (empty_o !== 1'b1) begin
        errors++;
        $display("FAIL wrap_empty[%0d]: empty=%b expected 1", i, empty_o);
      end
    end
  endtask

  task automatic test_random();
    write_buffer_entry_t head;
    logic exp_match;
    for (int c = 0; c < 400; c++) begin
      wr    = ($urandom_range(0, 99) < 45);
      done  = ($urandom_range(0, 99) < 40);
      addr  = {20'h00AB0, 8'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 2'($urandom)};
      data  = $urandom;
      width = mem_op_width_t'($urandom_range(0, 2));
      load_addr = {20'h00AB0, 8'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 2'($urandom)};
      #1;
      exp_match = 1'b0;
      foreach (mq[j]) if (same_word(mq[j].address, load_addr)) exp_match = 1'b1;
      head = (mreq && mq.size() != 0) ? mq[0] : '0;
      checks++;
      if (full_o !== (mq.size() == DEPTH) || empty_o !== (mq.size() == 0) ||
          mem_write_o !== mreq || load_match_o !== exp_match) begin
        errors++;
        $display("FAIL random_flags[%0d]: full=%b empty=%b req=%b match=%b expected %b/%b/%b/%b",
                 c, full_o, empty_o, mem_write_o, load_match_o,
                 (mq.size() == DEPTH), (mq.size() == 0), mreq, exp_match);
      end
      checks++;
      if (mem_address_o !== head.address || mem_data_o !== head.data ||
          mem_width_o !== head.width) begin
        errors++;
        $display("FAIL random_head[%0d]: addr=%h data=%h width=%0d expected %h/%h/%0d",
                 c, mem_address_o, mem_data_o, mem_width_o,
                 head.address, head.data, head.width);
      end
      tick();
    end
    wr = 1'b0; done = 1'b0;
  endtask

  initial begin
    mq.delete();
    mreq = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_load_match();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
